sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/pkg_ini.sv | 47 ++++
 rtl/rr_pick.sv | 35 +++
 rtl/sdram_arbiter.sv | 139 +++++++++++++
 tb/tb_sdram_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_ini.sv
// Shared definitions for the SDRAM arbiter slice.
//   arb_state_t    : arbiter FSM states (IDLE, ISSUE, WAIT_CMD, WAIT_DONE)
//   sdram_state_t  : controller state codes presented on st_sdram
//   lmr_t          : SDRAM load-mode-register layout
//   REQ_NONE/WR/RD : client/controller request codes (2'b11 is invalid)
//   clamp_nw       : limits a word count to the legal burst range 1..256
package pkg_ini;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_CMD  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  typedef enum logic [3:0] {
    INIT      = 4'd0,
    PRECHARGE = 4'd1,
    REFRESH   = 4'd2,
    LOAD_MODE = 4'd3,
    ACTIVE    = 4'd4,
    WR_CMD    = 4'd5,
    RD_CMD    = 4'd6,
    WR_BURST  = 4'd7,
    RD_BURST  = 4'd8
  } sdram_state_t;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       wr_burst_single;
    logic [1:0] op_mode;
    logic [2:0] cas_latency;
    logic       burst_type;
    logic [2:0] burst_len;
  } lmr_t;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_WR   = 2'b01;
  localparam logic [1:0] REQ_RD   = 2'b10;

  function automatic logic [8:0] clamp_nw(input logic [8:0] nw);
    if (nw == 9'd0) return 9'd1;
    if (nw > 9'd256) return 9'd256;
    return nw;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   elig  : one bit per client, high when the client may be granted
//   last  : index of the previously granted client
//   win   : first eligible index searching from last+1 (mod N)
//   valid : high when any client is eligible
module rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] last,
  output logic [W-1:0] win,
  output logic         valid
);

  always_comb begin
    int unsigned idx;
    logic [W-1:0] sel;
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    sel   = '0;
    // Offsets 1..N visit every client once, ending on last itself, so a
    // lone requester is still granted back-to-back.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      sel = W'(idx);
      if (!valid && elig[sel]) begin
        win   = sel;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter in front of a single SDRAM controller request port.
//   osc, rst              : clock, asynchronous active-high reset
//   st_sdram              : controller state (ACTIVE / WR_CMD / RD_CMD / other)
//   c_req/c_addr/c_nw     : per-client request code, word address, word count
//   c_data                : per-client 256-word write buffer
//   c_done                : one-cycle completion pulse to the granted client
//   gnt                   : current or last granted client
//   busy                  : high while a transaction is in flight
//   err                   : one-cycle pulse on command-handshake timeout
//   u_req/u_addr/u_nw/u_data : registered request toward the controller
// Read data is not routed here; clients take it from the controller's
// shared read buffer, qualified by their c_done pulse.
module sdram_arbiter
  import pkg_ini::*;
#(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned TMO_CYCLES = 1024,
  localparam int unsigned GW = $clog2(N_CLIENTS)
) (
  input  logic                             osc,
  input  logic                             rst,
  input  logic [3:0]                       st_sdram,
  input  logic [N_CLIENTS-1:0][1:0]        c_req,
  input  logic [N_CLIENTS-1:0][21:0]       c_addr,
  input  logic [N_CLIENTS-1:0][8:0]        c_nw,
  input  logic [N_CLIENTS-1:0][255:0][15:0] c_data,
  output logic [N_CLIENTS-1:0]             c_done,
  output logic [GW-1:0]                    gnt,
  output logic                             busy,
  output logic                             err,
  output logic [1:0]                       u_req,
  output logic [21:0]                      u_addr,
  output logic [8:0]                       u_nw,
  output logic [255:0][15:0]               u_data
);

  localparam int unsigned WDW = $clog2(TMO_CYCLES);
  localparam logic [GW-1:0] LAST_RST = GW'(N_CLIENTS - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TMO_CYCLES - 1);

  arb_state_t           state;
  logic [GW-1:0]        last_gnt;
  logic [1:0]           lat_req;
  logic [21:0]          lat_addr;
  logic [8:0]           lat_nw;
  logic [WDW-1:0]       wdog;
  logic [N_CLIENTS-1:0] elig;
  logic [GW-1:0]        pick_win;
  logic                 pick_valid;
  logic                 cmd_hit;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_elig
    assign elig[i] = (c_req[i] == REQ_WR) || (c_req[i] == REQ_RD);
  end

  rr_pick #(
    .N(N_CLIENTS),
    .W(GW)
  ) rr_i (
    .elig (elig),
    .last (last_gnt),
    .win  (pick_win),
    .valid(pick_valid)
  );

  always_comb begin
    cmd_hit = 1'b0;
    if (lat_req == REQ_WR) cmd_hit = (st_sdram == WR_CMD);
    else                   cmd_hit = (st_sdram == RD_CMD);
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= LAST_RST;
      gnt      <= '0;
      lat_req  <= REQ_NONE;
      lat_addr <= '0;
      lat_nw   <= '0;
      wdog     <= '0;
      u_req    <= REQ_NONE;
      u_addr   <= '0;
      u_nw     <= '0;
      u_data   <= '0;
      c_done   <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      c_done <= '0;
      err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (st_sdram == ACTIVE && pick_valid) begin
            gnt      <= pick_win;
            lat_req  <= c_req[pick_win];
            lat_addr <= c_addr[pick_win];
            lat_nw   <= clamp_nw(c_nw[pick_win]);
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // The write buffer is captured only here so the controller sees
          // one stable snapshot for the whole burst.
          u_req  <= lat_req;
          u_addr <= lat_addr;
          u_nw   <= lat_nw;
          u_data <= c_data[gnt];
          wdog   <= '0;
          state  <= WAIT_CMD;
        end
        WAIT_CMD: begin
          if (cmd_hit) begin
            u_req <= REQ_NONE;
            state <= WAIT_DONE;
          end else if (wdog == WD_LIMIT) begin
            u_req    <= REQ_NONE;
            err      <= 1'b1;
            busy     <= 1'b0;
            last_gnt <= gnt;
            state    <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (st_sdram == ACTIVE) begin
            c_done[gnt] <= 1'b1;
            last_gnt    <= gnt;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  import pkg_ini::*;

  localparam int unsigned NC  = 2;
  localparam int unsigned TMO = 16;
  localparam int unsigned GW  = $clog2(NC);

  logic                      osc;
  logic                      rst;
  logic [3:0]                st_sdram;
  logic [NC-1:0][1:0]        c_req;
  logic [NC-1:0][21:0]       c_addr;
  logic [NC-1:0][8:0]        c_nw;
  logic [NC-1:0][255:0][15:0] c_data;
  logic [NC-1:0]             c_done;
  logic [GW-1:0]             gnt;
  logic                      busy;
  logic                      err;
  logic [1:0]                u_req;
  logic [21:0]               u_addr;
  logic [8:0]                u_nw;
  logic [255:0][15:0]        u_data;

  sdram_arbiter #(
    .N_CLIENTS (NC),
    .TMO_CYCLES(TMO)
  ) dut (
    .osc     (osc),
    .rst     (rst),
    .st_sdram(st_sdram),
    .c_req   (c_req),
    .c_addr  (c_addr),
    .c_nw    (c_nw),
    .c_data  (c_data),
    .c_done  (c_done),
    .gnt     (gnt),
    .busy    (busy),
    .err     (err),
    .u_req   (u_req),
    .u_addr  (u_addr),
    .u_nw    (u_nw),
    .u_data  (u_data)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  int n_tests;
  int n_fail;

  // Transaction-level reference: one outstanding transfer record plus the
  // round-robin pointer; outputs are derived from where that record is.
  localparam int TX_NONE = 0;   // nothing in flight
  localparam int TX_WON  = 1;   // winner chosen, request not yet presented
  localparam int TX_SENT = 2;   // request presented, waiting for command
  localparam int TX_BURST = 3;  // command accepted, waiting for ACTIVE
  int                 m_where;
  int                 m_last;
  int                 m_wait;
  logic [1:0]         t_req;
  logic [21:0]        t_addr;
  logic [8:0]         t_nw;
  logic [GW-1:0]      e_gnt;
  logic               e_busy;
  logic               e_err;
  logic [NC-1:0]      e_done;
  logic [1:0]         e_ureq;
  logic [21:0]        e_uaddr;
  logic [8:0]         e_unw;
  logic [255:0][15:0] e_udata;

  function automatic logic [GW-1:0] cx(input int i);
    return GW'(i);
  endfunction

  function automatic logic [8:0] clampm(input logic [8:0] nw);
    int v;
    v = int'(nw);
    if (v < 1) v = 1;
    if (v > 256) v = 256;
    return 9'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_where = TX_NONE;
    m_last  = int'(NC) - 1;
    m_wait  = 0;
    t_req   = 2'b00;
    t_addr  = '0;
    t_nw    = '0;
    e_gnt   = '0;
    e_busy  = 1'b0;
    e_err   = 1'b0;
    e_done  = '0;
    e_ureq  = 2'b00;
    e_uaddr = '0;
    e_unw   = '0;
    e_udata = '0;
  endtask

  // Predicts the outputs after the coming posedge from the inputs now applied.
  task automatic model_step();
    int c;
    logic hit;
    if (rst) begin
      m_reset();
      return;
    end
    e_done = '0;
    e_err  = 1'b0;
    case (m_where)
      TX_NONE: begin
        if (st_sdram == ACTIVE) begin
          for (int k = 1; k <= int'(NC); k++) begin
            c = (m_last + k) % int'(NC);
            if (c_req[cx(c)] == 2'b01 || c_req[cx(c)] == 2'b10) begin
              e_gnt   = cx(c);
              t_req   = c_req[cx(c)];
              t_addr  = c_addr[cx(c)];
              t_nw    = clampm(c_nw[cx(c)]);
              e_busy  = 1'b1;
              m_where = TX_WON;
              break;
            end
          end
        end
      end
      TX_WON: begin
        e_ureq  = t_req;
        e_uaddr = t_addr;
        e_unw   = t_nw;
        e_udata = c_data[e_gnt];
        m_wait  = 0;
        m_where = TX_SENT;
      end
      TX_SENT: begin
        hit = (t_req == 2'b01 && st_sdram == WR_CMD) ||
              (t_req == 2'b10 && st_sdram == RD_CMD);
        if (hit) begin
          e_ureq  = 2'b00;
          m_where = TX_BURST;
        end else if (m_wait == int'(TMO) - 1) begin
          e_ureq  = 2'b00;
          e_err   = 1'b1;
          e_busy  = 1'b0;
          m_last  = int'(e_gnt);
          m_where = TX_NONE;
        end else begin
          m_wait++;
        end
      end
      default: begin
        if (st_sdram == ACTIVE) begin
          e_done[e_gnt] = 1'b1;
          e_busy  = 1'b0;
          m_last  = int'(e_gnt);
          m_where = TX_NONE;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    logic seen;
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("err", 64'(err), 64'(e_err));
    chk("c_done", 64'(c_done), 64'(e_done));
    chk("u_req", 64'(u_req), 64'(e_ureq));
    chk("u_addr", 64'(u_addr), 64'(e_uaddr));
    chk("u_nw", 64'(u_nw), 64'(e_unw));
    chk("done_onehot", 64'($countones(c_done) > 1), 64'(0));
    n_tests++;
    if (u_data !== e_udata) begin
      n_fail++;
      seen = 1'b0;
      for (int w = 0; w < 256; w++) begin
        if (!seen && u_data[8'(w)] !== e_udata[8'(w)]) begin
          seen = 1'b1;
          $display("FAIL u_data word %0d got=%h exp=%h at %0t", w, u_data[8'(w)], e_udata[8'(w)], $time);
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge osc);
    #1;
    check_outputs();
  endtask

  task automatic fill_data(input int i);
    for (int w = 0; w < 256; w++) c_data[cx(i)][8'(w)] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Bounded wait for the request to appear at the controller port.
  task automatic wait_issue(input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!ok) begin
        tick();
        if (u_req != 2'b00) ok = 1'b1;
      end
    end
    chk(name, 64'(ok), 64'(1));
  endtask

  // Controller side: accept the command, run a short burst, return to ACTIVE.
  task automatic finish_txn(input logic [3:0] cmd);
    st_sdram = cmd;
    tick();
    st_sdram = (cmd == WR_CMD) ? WR_BURST : RD_BURST;
    tick();
    tick();
    st_sdram = ACTIVE;
    tick();
  endtask

  task automatic rand_inputs();
    int r;
    for (int i = 0; i < int'(NC); i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      c_req[cx(i)] = 2'b00;
      else if (r < 6) c_req[cx(i)] = 2'b01;
      else if (r < 9) c_req[cx(i)] = 2'b10;
      else            c_req[cx(i)] = 2'b11;
      c_addr[cx(i)] = 22'($urandom);
      case ($urandom_range(0, 7))
        0: c_nw[cx(i)] = 9'd0;
        1: c_nw[cx(i)] = 9'd1;
        2: c_nw[cx(i)] = 9'd256;
        3: c_nw[cx(i)] = 9'd257;
        4: c_nw[cx(i)] = 9'd300;
        5: c_nw[cx(i)] = 9'd511;
        default: c_nw[cx(i)] = 9'($urandom_range(2, 255));
      endcase
      if ($urandom_range(0, 3) == 0) fill_data(i);
    end
    r = int'($urandom_range(0, 99));
    if (r < 40)      st_sdram = ACTIVE;
    else if (r < 55) st_sdram = WR_CMD;
    else if (r < 70) st_sdram = RD_CMD;
    else if (r < 80) st_sdram = WR_BURST;
    else if (r < 90) st_sdram = RD_BURST;
    else             st_sdram = REFRESH;
    rst = ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int got_k;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    st_sdram = INIT;
    c_req    = '0;
    c_addr   = '0;
    c_nw     = '0;
    c_data   = '0;
    m_reset();

    // Reset state
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ureq", 64'(u_req), 64'(0));
    chk("rst_udata_nz", 64'(u_data != '0), 64'(0));
    rst = 1'b0;

    // Single write from client 0
    st_sdram  = ACTIVE;
    c_req[0]  = 2'b01;
    c_addr[0] = 22'h000100;
    c_nw[0]   = 9'd256;
    fill_data(0);
    tick();
    chk("w_busy_lit", 64'(busy), 64'(1));
    chk("w_ureq_early", 64'(u_req), 64'(0));
    c_req[0]  = 2'b00;
    c_addr[0] = 22'h3fffff;
    tick();
    chk("w_ureq_lit", 64'(u_req), 64'(2'b01));
    chk("w_uaddr_lit", 64'(u_addr), 64'(22'h000100));
    chk("w_unw_lit", 64'(u_nw), 64'(256));
    fill_data(0);
    repeat (3) tick();
    chk("w_hold_lit", 64'(u_req), 64'(2'b01));
    finish_txn(WR_CMD);
    chk("w_done_lit", 64'(c_done), 64'(2'b01));
    chk("w_busy_end", 64'(busy), 64'(0));

    // Fairness between two continuous readers
    do_reset();
    st_sdram = ACTIVE;
    c_req[0] = 2'b10;
    c_req[1] = 2'b10;
    c_nw[0]  = 9'd8;
    c_nw[1]  = 9'd8;
    for (int t = 0; t < 4; t++) begin
      wait_issue("fair_issue");
      chk("fair_gnt_lit", 64'(gnt), 64'(t % 2));
      finish_txn(RD_CMD);
      chk("fair_done_lit", 64'(c_done), 64'((t % 2 == 0) ? 1 : 2));
    end

    // Word-count clamping at both ends
    c_req[1] = 2'b00;
    c_req[0] = 2'b01;
    c_nw[0]  = 9'd0;
    wait_issue("clamp0_issue");
    chk("clamp0_lit", 64'(u_nw), 64'(1));
    chk("clamp0_model", 64'(e_unw), 64'(1));
    c_req[0] = 2'b00;
    finish_txn(WR_CMD);
    c_req[1] = 2'b10;
    c_nw[1]  = 9'd300;
    wait_issue("clamp300_issue");
    chk("clamp300_lit", 64'(u_nw), 64'(256));
    chk("clamp300_gnt", 64'(gnt), 64'(1));
    c_req[1] = 2'b00;
    finish_txn(RD_CMD);

    // Watchdog timeout with the controller stuck in ACTIVE
    c_req[0] = 2'b01;
    c_req[1] = 2'b10;
    wait_issue("tmo_issue");
    chk("tmo_gnt0", 64'(gnt), 64'(0));
    got_k = 0;
    for (int k = 1; k <= int'(TMO) + 4; k++) begin
      if (got_k == 0) begin
        tick();
        if (err) got_k = k;
      end
    end
    chk("tmo_cycles_lit", 64'(got_k), 64'(TMO));
    chk("tmo_ureq_lit", 64'(u_req), 64'(0));
    chk("tmo_done_lit", 64'(c_done), 64'(0));
    wait_issue("tmo_next_issue");
    chk("tmo_next_gnt", 64'(gnt), 64'(1));
    c_req[0] = 2'b00;
    c_req[1] = 2'b00;
    finish_txn(RD_CMD);

    // Invalid code on client 0 is never granted
    c_req[0] = 2'b11;
    c_req[1] = 2'b10;
    for (int t = 0; t < 2; t++) begin
      wait_issue("inv_issue");
      chk("inv_gnt_lit", 64'(gnt), 64'(1));
      finish_txn(RD_CMD);
      chk("inv_done_lit", 64'(c_done), 64'(2'b10));
    end

    // Asynchronous reset during the burst
    c_req[0] = 2'b00;
    wait_issue("rstmid_issue");
    st_sdram = RD_CMD;
    tick();
    st_sdram = RD_BURST;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_gnt", 64'(gnt), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_ureq", 64'(u_req), 64'(0));
    chk("rstmid_uaddr", 64'(u_addr), 64'(0));
    chk("rstmid_unw", 64'(u_nw), 64'(0));
    chk("rstmid_udata_nz", 64'(u_data != '0), 64'(0));
    chk("rstmid_done", 64'(c_done), 64'(0));
    chk("rstmid_err", 64'(err), 64'(0));
    st_sdram = ACTIVE;
    tick();
    rst = 1'b0;
    c_req[0] = 2'b10;
    c_req[1] = 2'b10;
    wait_issue("rstmid_next_issue");
    chk("rstmid_next_gnt", 64'(gnt), 64'(0));
    c_req = '0;
    finish_txn(RD_CMD);

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
